// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the round-robin memory controller.
package mem_ctrl_pkg;

  localparam int unsigned AW_DEF = 16;
  localparam int unsigned DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Stored parity bit for a data word; callers zero-extend, which leaves parity unchanged.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request searching upward from ptr+1 with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic          found;
  logic [IW-1:0] cand;

  // Scan NREQ candidates starting just after the last winner.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/mem_rr_ctrl.sv
// Shares one parity-protected memory between NREQ requesters, one transaction at a time.
module mem_rr_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_perr,
  output logic               mem_write,
  output logic               mem_read,
  output logic [AW-1:0]      mem_address,
  output logic [DW-1:0]      mem_data_in,
  input  logic [DW:0]        mem_data_out,
  output logic [15:0]        err_count
);

  localparam int unsigned   IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned   CW      = 16;
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, gnt_q, win_idx;
  logic [NREQ-1:0] win_grant;
  logic            we_q;
  logic            accept;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (win_grant),
    .idx   (win_idx)
  );

  assign accept = (state_q == IDLE) && (|req_valid);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: writes skip the capture cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = we_q ? RESP : CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded handshake and strobe outputs.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    case (state_q)
      IDLE:    req_ready = win_grant;
      ACCESS: begin
        mem_write = we_q;
        mem_read  = !we_q;
      end
      RESP:    rsp_valid[gnt_q] = 1'b1;
      default: ;
    endcase
  end

  // Request latch, read capture with parity check, and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= IW'(NREQ - 1);
      gnt_q       <= '0;
      we_q        <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      rsp_rdata   <= '0;
      rsp_perr    <= 1'b0;
      err_count   <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          ptr_q       <= win_idx;
          gnt_q       <= win_idx;
          we_q        <= req_we[win_idx];
          mem_address <= req_addr[win_idx*AW +: AW];
          mem_data_in <= req_wdata[win_idx*DW +: DW];
          rsp_perr    <= 1'b0;
        end
        CAPTURE: begin
          rsp_rdata <= mem_data_out[DW-1:0];
          rsp_perr  <= mem_data_out[DW] ^ even_parity(64'(mem_data_out[DW-1:0]));
        end
        RESP: if (rsp_perr && (err_count != CNT_MAX)) err_count <= err_count + CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_rr_ctrl.md
Name: mem_rr_ctrl

Overview:
Round-robin arbiter and sequencer that shares one my_mem instance (8-bit data, 16-bit address, 9-bit read data with parity in bit 8) between NREQ requesters. It accepts one request at a time using a valid/ready handshake and drives the memory's write/read strobes for exactly one cycle. For reads it captures data_out, strips and checks the parity bit, and returns the data with a per-requester response pulse. It sits between the client blocks and my_mem.

Parameters:
NREQ, 2, number of requesters (2..8)
AW, 16, address width
DW, 8, data width (the memory read bus is DW+1 wide)

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_we  in  NREQ  1=write, 0=read
req_addr  in  NREQ*AW  packed per-requester address, requester i at [i*AW +: AW]
req_wdata  in  NREQ*DW  packed per-requester write data
req_ready  out  NREQ  one-hot grant/accept
rsp_valid  out  NREQ  one-hot single-cycle completion pulse
rsp_rdata  out  DW  read data, valid with rsp_valid
rsp_perr  out  1  parity error flag, valid with rsp_valid (reads only)
mem_write  out  1  to my_mem write
mem_read  out  1  to my_mem read
mem_address  out  AW  to my_mem address
mem_data_in  out  DW  to my_mem data_in
mem_data_out  in  DW+1  from my_mem data_out; bit DW is parity
err_count  out  16  saturating count of parity errors

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0: req_ready, rsp_valid, rsp_rdata, rsp_perr, mem_write, mem_read, mem_address, mem_data_in, err_count. The RR pointer is NREQ-1, so requester 0 has first priority.
- States:
  - IDLE: if any req_valid is high, the winner g is the first set bit searching from (ptr+1) mod NREQ upward with wrap. req_ready[g]=1 combinationally in IDLE only. On that edge: latch we/addr/wdata/g, set ptr=g, go to ACCESS.
  - ACCESS: exactly one of mem_write/mem_read is 1, chosen by the latched we. mem_address and mem_data_in hold the latched values, which are registered and stable for the whole cycle. Write goes to RESP; read goes to CAPTURE.
  - CAPTURE (read only): strobes are 0. At the end of this cycle, register rsp_rdata=mem_data_out[DW-1:0] and rsp_perr = mem_data_out[DW] XOR (^mem_data_out[DW-1:0]). This is the even-parity check: stored parity = ^data.
  - RESP: rsp_valid[g]=1 for one cycle, then go to IDLE. For writes, rsp_perr=0 and rsp_rdata is unchanged.
- Latency from the accept edge to rsp_valid high: write 2 cycles, read 3 cycles. The next accept can occur at the earliest in the IDLE cycle after RESP. Peak throughput is one op per 3 cycles (write) or 4 cycles (read).
- Requesters hold valid/we/addr/wdata stable until req_ready. Dropping req_valid before acceptance is legal and yields no transaction.
- req_ready and rsp_valid are never asserted outside IDLE and RESP respectively. At most one bit of each is set.
- Simultaneous requests are served in RR order, and no requester waits more than NREQ-1 grants.
- err_count increments on each RESP cycle with rsp_perr=1 and saturates at 16'hFFFF.
- mem_address and mem_data_in keep their last values while IDLE. The strobes are 0 outside ACCESS.
- Reset mid-operation: the in-flight transaction is dropped with no rsp_valid, strobes drop immediately, and err_count clears.

Decomposition:
- Package mem_ctrl_pkg: state enum (IDLE, ACCESS, CAPTURE, RESP), AW/DW defaults, function even_parity(data).
- Sub-module rr_arbiter (NREQ): inputs req, ptr; outputs one-hot grant and encoded index. Purely combinational, reused by other shared-resource blocks.

Test Plan:
1. Requester 0 writes 8'hA5 to 16'h1234, then reads 16'h1234 -> write rsp_valid[0] 2 cycles after accept. Read rsp_valid[0] 3 cycles after accept with rsp_rdata=8'hA5, rsp_perr=0.
2. Both requesters valid in the same cycle after reset (req0 write 16'h0010=8'h11, req1 write 16'h0020=8'h22) -> req0 granted first, then req1. Subsequent reads return 8'h11 and 8'h22.
3. Both requesters hold continuous reads for 6 transactions -> grants alternate 0,1,0,1,0,1. Exactly one mem_read pulse per transaction.
4. Memory model forces mem_data_out=9'h1_03 on a read (parity mismatch) -> rsp_perr=1, rsp_rdata=8'h03, err_count goes 0->1. A subsequent clean read leaves err_count=1.
5. rst_n pulled low during CAPTURE of a read -> all outputs 0 asynchronously, no rsp_valid. After release, requester 0 has priority again.
6. req_valid[1] pulsed for one cycle while the controller is in ACCESS for req0 -> no grant to requester 1 and no extra memory strobe.
